conv_run_sequencer: RTL

//  Run-control + address scheduler for the conv datapath in MyDesign. On the dut_run handshake it:
//  - reads the dimension header from the input SRAM;
//  - streams input/weight SRAM read addresses, one tap per cycle, flagging first/last tap to the MAC;
//  - issues output SRAM write strobes/addresses aligned to the MAC result.
//  The MAC owns the write data; this block owns every address, every strobe and dut_busy.

---
 rtl/conv_run_seq_pkg.sv | 25 ++
 rtl/conv_run_sequencer_addr_gen.sv | 70 +++++++
 rtl/conv_run_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/conv_run_seq_pkg.sv
// Shared types and constants for the conv run sequencer and its address generator.
package conv_run_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_REQ,
      HDR_WAIT,
      RUN,
      DRAIN,
      DONE
   } state_t;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] HDR_ADDR = 12'h000;
   localparam logic [ADDR_W-1:0] IN_BASE  = 12'h001;
   localparam logic [ADDR_W-1:0] W_BASE   = 12'h000;

   // Header word is legal only when the whole 16-bit value lies in [lo, hi].
   function automatic logic n_in_range(input logic [DATA_W-1:0] n, input int lo, input int hi);
      return (int'(n) >= lo) && (int'(n) <= hi);
   endfunction

endpackage

// File: rtl/conv_run_sequencer_addr_gen.sv
// Nested r/c/i/j tap counters (j innermost) and the input/weight/output address arithmetic.
module conv_addr_gen
   import conv_run_seq_pkg::*;
#(
   parameter int K = 3
)
(
   input  logic              clk,
   input  logic              i_reset_b,
   input  logic              i_start,
   input  logic              i_step,
   input  logic [5:0]        i_n,
   output logic [ADDR_W-1:0] o_in_addr,
   output logic [ADDR_W-1:0] o_w_addr,
   output logic [ADDR_W-1:0] o_out_idx,
   output logic              o_first,
   output logic              o_last,
   output logic              o_final
);

   localparam int KW = (K > 1) ? $clog2(K) : 1;

   logic [5:0]        r_r;
   logic [5:0]        r_c;
   logic [KW-1:0]     r_i;
   logic [KW-1:0]     r_j;
   logic [5:0]        w_m;
   logic [ADDR_W-1:0] w_row;
   logic [ADDR_W-1:0] w_col;

   assign w_m = i_n - 6'(K - 1);

   always_ff @(posedge clk) begin
      if (!i_reset_b || i_start) begin
         r_r <= '0;
         r_c <= '0;
         r_i <= '0;
         r_j <= '0;
      end else if (i_step) begin
         if (r_j == KW'(K - 1)) begin
            r_j <= '0;
            if (r_i == KW'(K - 1)) begin
               r_i <= '0;
               if (r_c == w_m - 6'd1) begin
                  r_c <= '0;
                  r_r <= r_r + 6'd1;
               end else begin
                  r_c <= r_c + 6'd1;
               end
            end else begin
               r_i <= r_i + KW'(1);
            end
         end else begin
            r_j <= r_j + KW'(1);
         end
      end
   end

   // Products are formed at 12 bits; legal N keeps every address below 4096.
   assign w_row     = ADDR_W'(r_r) + ADDR_W'(r_i);
   assign w_col     = ADDR_W'(r_c) + ADDR_W'(r_j);
   assign o_in_addr = IN_BASE + w_row * ADDR_W'(i_n) + w_col;
   assign o_w_addr  = W_BASE + ADDR_W'(r_i) * ADDR_W'(K) + ADDR_W'(r_j);
   assign o_out_idx = ADDR_W'(r_r) * ADDR_W'(w_m) + ADDR_W'(r_c);

   assign o_first = (r_i == '0) && (r_j == '0);
   assign o_last  = (r_i == KW'(K - 1)) && (r_j == KW'(K - 1));
   assign o_final = o_last && (r_r == w_m - 6'd1) && (r_c == w_m - 6'd1);

endmodule

// File: rtl/conv_run_sequencer.sv
// Run control, tap address streaming and output write strobes for the conv datapath.
// Optional CONV_RUN_SEQ_CYCLE_CNT_EN adds a cycle_count output counting busy cycles per job.
module conv_run_sequencer
   import conv_run_seq_pkg::*;
#(
   parameter int K       = 3,
   parameter int MAX_N   = 63,
   parameter int MAC_LAT = 1
)
(
   input  logic              clk,
   input  logic              reset_b,
   input  logic              dut_run,
   output logic              dut_busy,
   output logic [ADDR_W-1:0] dut_sram_read_address,
   input  logic [DATA_W-1:0] sram_dut_read_data,
   output logic [ADDR_W-1:0] dut_wmem_read_address,
   output logic              mac_valid,
   output logic              mac_first,
   output logic              mac_last,
   output logic              dut_sram_write_enable,
   output logic [ADDR_W-1:0] dut_sram_write_address
`ifdef CONV_RUN_SEQ_CYCLE_CNT_EN
   ,
   output logic [31:0]       cycle_count
`endif
);

   state_t            r_state;
   state_t            w_next;
   logic              r_armed;
   logic              r_busy;
   logic [5:0]        r_n;
   logic [5:0]        w_n_eff;
   logic              w_accept;
   logic              w_hdr_ok;
   logic              w_issue;
   logic              w_start;
   logic              w_pend;

   logic [ADDR_W-1:0] r_in_addr;
   logic [ADDR_W-1:0] r_w_addr;
   logic              r_cur_first;
   logic              r_cur_last;
   logic              r_cur_final;
   logic [ADDR_W-1:0] r_cur_idx;

   logic              r_mac_vld;
   logic              r_mac_first;
   logic [MAC_LAT:0]  r_tag_vld;
   logic [ADDR_W-1:0] r_tag_idx [0:MAC_LAT];

   logic [ADDR_W-1:0] w_in_addr;
   logic [ADDR_W-1:0] w_w_addr;
   logic [ADDR_W-1:0] w_out_idx;
   logic              w_first;
   logic              w_last;
   logic              w_final;

   assign w_accept = (r_state == IDLE) && dut_run && r_armed;
   assign w_hdr_ok = n_in_range(sram_dut_read_data, K, MAX_N);
   // The header word is still on the bus while tap 0 is computed.
   assign w_n_eff  = (r_state == HDR_WAIT) ? sram_dut_read_data[5:0] : r_n;

   conv_addr_gen #(.K(K)) u_addr_gen (
      .clk       (clk),
      .i_reset_b (reset_b),
      .i_start   (w_start),
      .i_step    (w_issue),
      .i_n       (w_n_eff),
      .o_in_addr (w_in_addr),
      .o_w_addr  (w_w_addr),
      .o_out_idx (w_out_idx),
      .o_first   (w_first),
      .o_last    (w_last),
      .o_final   (w_final)
   );

   // Leave DRAIN once the final tag is one stage from the write strobe, so busy drops right after it.
   always_comb begin
      w_pend = 1'b0;
      for (int p = 0; p < MAC_LAT - 1; p++) begin
         w_pend = w_pend | r_tag_vld[p];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_issue = 1'b0;
      w_start = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = HDR_REQ;
         end
         HDR_REQ: begin
            w_start = 1'b1;
            w_next  = HDR_WAIT;
         end
         HDR_WAIT: begin
            if (w_hdr_ok) begin
               w_issue = 1'b1;
               w_next  = RUN;
            end else begin
               w_next  = DONE;
            end
         end
         RUN: begin
            if (r_cur_final) w_next = DRAIN;
            else             w_issue = 1'b1;
         end
         DRAIN: begin
            if (!w_pend) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_armed     <= 1'b1;
         r_busy      <= 1'b0;
         r_n         <= '0;
         r_in_addr   <= '0;
         r_w_addr    <= '0;
         r_cur_first <= 1'b0;
         r_cur_last  <= 1'b0;
         r_cur_final <= 1'b0;
         r_cur_idx   <= '0;
         r_mac_vld   <= 1'b0;
         r_mac_first <= 1'b0;
         r_tag_vld   <= '0;
         for (int p = 0; p <= MAC_LAT; p++) begin
            r_tag_idx[p] <= '0;
         end
      end else begin
         if (w_accept)      r_armed <= 1'b0;
         else if (!dut_run) r_armed <= 1'b1;

         if (w_accept)              r_busy <= 1'b1;
         else if (r_state == DONE)  r_busy <= 1'b0;

         if (r_state == HDR_WAIT) r_n <= sram_dut_read_data[5:0];

         if (w_accept) begin
            r_in_addr <= HDR_ADDR;
         end else if (w_issue) begin
            r_in_addr   <= w_in_addr;
            r_w_addr    <= w_w_addr;
            r_cur_first <= w_first;
            r_cur_last  <= w_last;
            r_cur_final <= w_final;
            r_cur_idx   <= w_out_idx;
         end

         // Operands of the tap addressed in RUN appear on the buses one cycle later.
         r_mac_vld    <= (r_state == RUN);
         r_mac_first  <= (r_state == RUN) && r_cur_first;
         r_tag_vld[0] <= (r_state == RUN) && r_cur_last;
         r_tag_idx[0] <= r_cur_idx;
         for (int p = 1; p <= MAC_LAT; p++) begin
            r_tag_vld[p] <= r_tag_vld[p-1];
            r_tag_idx[p] <= r_tag_idx[p-1];
         end
      end
   end

`ifdef CONV_RUN_SEQ_CYCLE_CNT_EN
   logic [31:0] r_cycle_cnt;

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         r_cycle_cnt <= '0;
      end else if (w_accept) begin
         r_cycle_cnt <= '0;
      end else if (r_busy) begin
         r_cycle_cnt <= r_cycle_cnt + 32'd1;
      end
   end

   assign cycle_count = r_cycle_cnt;
`endif

   assign dut_busy               = r_busy;
   assign dut_sram_read_address  = r_in_addr;
   assign dut_wmem_read_address  = r_w_addr;
   assign mac_valid              = r_mac_vld;
   assign mac_first              = r_mac_first;
   assign mac_last               = r_tag_vld[0];
   assign dut_sram_write_enable  = r_tag_vld[MAC_LAT];
   assign dut_sram_write_address = r_tag_idx[MAC_LAT];

endmodule
